// File: rtl/exec_mult_seq.sv
// exec_mult_seq: iterative shift-add multiplier for MUL/MULH in the execute stage.
// Operands are converted to magnitudes on acceptance, multiplied unsigned over
// WIDTH cycles, and the sign is restored when the product is retired.
module exec_mult_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active-low
    input  logic             start,
    input  logic             flush,
    input  logic             signed_op,
    input  logic             hi_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ofl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               hi_q, hi_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ofl_q, ofl_d;

    logic               accept;
    logic               last_iter;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   acc_next, mplier_next;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic               prod_ofl;

    // A new op is taken only from IDLE, and a simultaneous flush rejects it.
    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        stall   = accept || (state_q == S_RUN);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE) && !flush;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                if (flush)          state_d = S_IDLE;
                else if (last_iter) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand conditioning, one shift-add step, and final sign/half selection.
    always_comb begin
        sign_a   = signed_op && op_a[WIDTH-1];
        sign_b   = signed_op && op_b[WIDTH-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;

        // Carry of the (W+1)-bit add shifts into the top of the accumulator.
        step_sum    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_next    = step_sum[WIDTH:1];
        mplier_next = {step_sum[0], mplier_q[WIDTH-1:1]};

        prod_mag = {acc_next, mplier_next};
        prod     = neg_q ? -prod_mag : prod_mag;
        prod_ofl = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                         : (|prod[2*WIDTH-1:WIDTH]);

        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        ofl_d    = ofl_q;

        if (accept) begin
            mcand_d  = mag_a;
            mplier_d = mag_b;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = sign_a ^ sign_b;
            hi_d     = hi_sel;
            sgn_d    = signed_op;
        end else if (state_q == S_RUN && !flush) begin
            acc_d    = acc_next;
            mplier_d = mplier_next;
            cnt_d    = cnt_q + CNT_W'(1);
            // Product is registered on the final step so it is stable in DONE
            // and holds afterwards.
            if (last_iter) begin
                result_d = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                ofl_d    = prod_ofl;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ofl_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ofl_q    <= ofl_d;
        end
    end

    assign result = result_q;
    assign ofl    = ofl_q;

endmodule

// File: tb/tb_exec_mult_seq.sv
// Self-checking bench for exec_mult_seq: directed products, randomized
// back-to-back ops against an arithmetic model, start held, flush and reset.
module tb_exec_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        signed_op = 1'b0;
    logic        hi_sel = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, stall, done, ofl;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    exec_mult_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .signed_op(signed_op), .hi_sel(hi_sel), .op_a(op_a), .op_b(op_b),
        .busy(busy), .stall(stall), .done(done), .result(result), .ofl(ofl)
    );

    always #5 clk = ~clk;

    // Reference: full-precision product, then half select and fit test.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic h,
                                  output logic [15:0] r, output logic o);
        longint pa, pb, p;
        logic [31:0] p32;
        if (s) begin
            pa = $signed(a);
            pb = $signed(b);
        end else begin
            pa = {48'd0, a};
            pb = {48'd0, b};
        end
        p   = pa * pb;
        p32 = p[31:0];
        r   = h ? p32[31:16] : p32[15:0];
        if (s) o = (p32[31:16] != {16{p32[15]}});
        else   o = (p32[31:16] != 16'd0);
    endfunction

    // Issue one op at the next negedge; cycle 0 is the start cycle. Returns the
    // cycle in which done was seen (-1 on timeout) and the number of stall cycles.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic h, input bit scramble,
                          output logic [15:0] r, output logic o,
                          output int lat, output int stalls);
        r = 'x;
        o = 1'bx;
        lat = -1;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; signed_op = s; hi_sel = h;
        #1;
        stalls = stall ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                op_a = 16'($urandom); op_b = 16'($urandom);
                signed_op = 1'($urandom); hi_sel = 1'($urandom);
            end
            #1;
            if (done) begin
                lat = c; r = result; o = ofl;
                break;
            end
            if (stall) stalls++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, stall, done, ofl} !== 4'b0000 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset: busy=%b stall=%b done=%b ofl=%b result=%h, want all 0",
                     busy, stall, done, ofl, result);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] va[5] = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h8000};
        logic [15:0] vb[5] = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h0007, 16'h8000};
        logic        vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vh[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] er[5] = '{16'h000F, 16'h0001, 16'hFFFE, 16'hFFF2, 16'h4000};
        logic        eo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] r;
        logic o;
        int lat, stalls;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], vh[i], 1'b0, r, o, lat, stalls);
            checks++;
            if (lat !== 17 || stalls !== 17) begin
                errors++;
                $display("FAIL directed_latency[%0d]: done_cycle=%0d stalls=%0d, want 17/17",
                         i, lat, stalls);
            end
            checks++;
            if (r !== er[i] || o !== eo[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: result=%h ofl=%b, want %h/%b",
                         i, r, o, er[i], eo[i]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [15:0] corner[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        logic [15:0] a, b, r, er;
        logic s, h, o, eo;
        int lat, stalls;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : 16'($urandom);
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : 16'($urandom);
            s = 1'($urandom);
            h = 1'($urandom);
            model(a, b, s, h, er, eo);
            run_op(a, b, s, h, 1'b1, r, o, lat, stalls);
            checks++;
            if (lat !== 17 || r !== er || o !== eo) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h s=%b h=%b: cycle=%0d result=%h ofl=%b, want 17/%h/%b",
                         i, a, b, s, h, lat, r, o, er, eo);
            end
        end
    endtask

    task automatic test_start_held();
        int ndone = 0;
        int first = -1;
        int second = -1;
        logic [15:0] r1 = 'x;
        logic [15:0] r2 = 'x;
        @(negedge clk);
        start = 1'b1; op_a = 16'h0003; op_b = 16'h0005; signed_op = 1'b0; hi_sel = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = c; r1 = result;
                    op_a = 16'h0100; op_b = 16'h0010;
                end else begin
                    second = c; r2 = result;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first !== 17 || r1 !== 16'h000F) begin
            errors++;
            $display("FAIL held_first: cycle=%0d result=%h, want 17/000f", first, r1);
        end
        checks++;
        if (second !== 35 || r2 !== 16'h1000 || ndone !== 2) begin
            errors++;
            $display("FAIL held_second: cycle=%0d result=%h pulses=%0d, want 35/1000/2",
                     second, r2, ndone);
        end
        @(negedge clk);
    endtask

    // Abort at RUN cycle 8 by flush (use_rst=0) or by reset (use_rst=1).
    task automatic test_abort(input bit use_rst);
        int ndone = 0;
        logic [15:0] r, er;
        logic o, eo;
        int lat, stalls;
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h0056; signed_op = 1'b0; hi_sel = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) begin
                if (use_rst) rst = 1'b0;
                else         flush = 1'b1;
            end
            if (c == 9) begin
                rst = 1'b1; flush = 1'b0;
            end
            #1;
            if (done) ndone++;
            if (c == 9) begin
                checks++;
                if (busy !== 1'b0 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle(rst=%0d): busy=%b stall=%b, want 0/0",
                             use_rst, busy, stall);
                end
                if (use_rst) begin
                    checks++;
                    if (result !== 16'h0000 || ofl !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_rst_clear: result=%h ofl=%b, want 0000/0", result, ofl);
                    end
                end
            end
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_no_done(rst=%0d): pulses=%0d, want 0", use_rst, ndone);
        end
        model(16'hABCD, 16'h0F0F, 1'b1, 1'b1, er, eo);
        run_op(16'hABCD, 16'h0F0F, 1'b1, 1'b1, 1'b1, r, o, lat, stalls);
        checks++;
        if (lat !== 17 || r !== er || o !== eo) begin
            errors++;
            $display("FAIL abort_recover(rst=%0d): cycle=%0d result=%h ofl=%b, want 17/%h/%b",
                     use_rst, lat, r, o, er, eo);
        end
    endtask

    task automatic test_flush_edges();
        // flush together with start in IDLE rejects the request
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_a = 16'h0002; op_b = 16'h0002;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_stall: stall=%b, want 0", stall);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_busy: busy=%b, want 0", busy);
        end
        // flush during the DONE cycle suppresses the pulse
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; hi_sel = 1'b0;
        repeat (17) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_cycle: done=%b busy=%b, want 0/1", done, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_next: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_start_held();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
